// File: rtl/rtc_ts_capture.sv
// rtc_ts_capture: captures the RTC time (seconds + ns/fraction) together with a
// caller tag on each rising edge of ts_trig. Entries go into a small
// first-word-fall-through queue. When the queue is full, new events are dropped
// and recorded in a sticky overflow flag and a saturating drop counter.
module rtc_ts_capture #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [37:0]             time_reg_ns,
    input  logic [47:0]             time_reg_sec,
    input  logic                    ts_trig,
    input  logic [TAG_W-1:0]        ts_tag,
    input  logic                    q_rd,
    input  logic                    ovf_clr,
    output logic                    q_valid,
    output logic [47:0]             q_sec,
    output logic [37:0]             q_ns,
    output logic [TAG_W-1:0]        q_tag,
    output logic [$clog2(DEPTH):0]  q_cnt,
    output logic                    q_ovf,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [47:0]      mem_sec [DEPTH];
    logic [37:0]      mem_ns  [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          trig_d;

    logic          cap;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

    // Previous ts_trig; reset to 1 so a strobe held high through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d <= 1'b1;
        end else begin
            trig_d <= ts_trig;
        end
    end

    // Event detection and queue control decisions for this cycle.
    always_comb begin
        cap   = ts_trig & ~trig_d;
        full  = (cnt == FULL_CNT);
        pop   = q_rd & (cnt != '0);
        // A pop on a full queue frees the head slot, which is the slot the new
        // entry lands in (wr_ptr == rd_ptr when full), so both are accepted.
        wr_en = cap & (~full | pop);
        drop  = cap & full & ~pop;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; seconds, ns and tag are all taken from the capture cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_sec[wr_ptr] <= time_reg_sec;
            mem_ns[wr_ptr]  <= time_reg_ns;
            mem_tag[wr_ptr] <= ts_tag;
        end
    end

    // Sticky overflow (a drop beats a clear) and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_ovf    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop) begin
                q_ovf <= 1'b1;
            end else if (ovf_clr) begin
                q_ovf <= 1'b0;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Fall-through head presentation, forced to zero while the queue is empty.
    always_comb begin
        q_valid = (cnt != '0);
        q_cnt   = cnt;
        q_sec   = '0;
        q_ns    = '0;
        q_tag   = '0;
        if (q_valid) begin
            q_sec = mem_sec[rd_ptr];
            q_ns  = mem_ns[rd_ptr];
            q_tag = mem_tag[rd_ptr];
        end
    end

endmodule

// File: tb/tb_rtc_ts_capture.sv
// Testbench for rtc_ts_capture: an RTC model running at 8 ns per cycle drives the
// time inputs; a scoreboard queue holds the expected entries and is compared on
// every pop, with occupancy and flags compared after every clock.
module tb_rtc_ts_capture;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 16;
    localparam int unsigned NS_PER_SEC = 1000000000;
    localparam logic [7:0]  FRAC = 8'h5A;

    typedef struct {
        logic [47:0]      sec;
        logic [37:0]      ns;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [37:0]            time_reg_ns;
    logic [47:0]            time_reg_sec;
    logic                   ts_trig;
    logic [TAG_W-1:0]       ts_tag;
    logic                   q_rd;
    logic                   ovf_clr;
    logic                   q_valid;
    logic [47:0]            q_sec;
    logic [37:0]            q_ns;
    logic [TAG_W-1:0]       q_tag;
    logic [$clog2(DEPTH):0] q_cnt;
    logic                   q_ovf;
    logic [7:0]             drop_cnt;

    int checks = 0;
    int errors = 0;

    // RTC model state
    int unsigned rtc_ns;
    logic [47:0] rtc_sec;

    // reference model state
    entry_t      sb[$];
    logic        m_trig_d = 1'b1;
    logic        m_ovf    = 1'b0;
    int unsigned m_drop   = 0;

    rtc_ts_capture #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .time_reg_ns(time_reg_ns), .time_reg_sec(time_reg_sec),
        .ts_trig(ts_trig), .ts_tag(ts_tag),
        .q_rd(q_rd), .ovf_clr(ovf_clr),
        .q_valid(q_valid), .q_sec(q_sec), .q_ns(q_ns), .q_tag(q_tag),
        .q_cnt(q_cnt), .q_ovf(q_ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive_rtc();
        logic [31:0] ns32;
        ns32         = rtc_ns;
        time_reg_ns  = {ns32[29:0], FRAC};
        time_reg_sec = rtc_sec;
    endtask

    task automatic load_rtc(input logic [47:0] s, input int unsigned n);
        rtc_sec = s;
        rtc_ns  = n;
        drive_rtc();
    endtask

    // One clock: pop-compare head, advance model, clock DUT, compare state, advance RTC.
    task automatic step();
        bit     cap;
        bit     dropped;
        entry_t e;
        if (q_rd && sb.size() != 0) begin
            checks++;
            if (q_sec !== sb[0].sec || q_ns !== sb[0].ns || q_tag !== sb[0].tag) begin
                errors++;
                $display("FAIL pop_head: got sec=%0d ns=%h tag=%h, expected sec=%0d ns=%h tag=%h",
                         q_sec, q_ns, q_tag, sb[0].sec, sb[0].ns, sb[0].tag);
            end
        end
        if (rst) begin
            sb.delete();
            m_ovf    = 1'b0;
            m_drop   = 0;
            m_trig_d = 1'b1;
        end else begin
            cap     = ts_trig && !m_trig_d;
            dropped = 1'b0;
            if (q_rd && sb.size() != 0) void'(sb.pop_front());
            if (cap) begin
                if (sb.size() < DEPTH) begin
                    e.sec = time_reg_sec;
                    e.ns  = time_reg_ns;
                    e.tag = ts_tag;
                    sb.push_back(e);
                end else begin
                    dropped = 1'b1;
                    if (m_drop != 255) m_drop++;
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_trig_d = ts_trig;
        end
        @(posedge clk);
        #1;
        checks++;
        if (q_cnt !== ($clog2(DEPTH)+1)'(sb.size())) begin
            errors++;
            $display("FAIL q_cnt: got %0d, expected %0d", q_cnt, sb.size());
        end
        checks++;
        if (q_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL q_valid: got %b, expected %b", q_valid, sb.size() != 0);
        end
        checks++;
        if (q_ovf !== m_ovf) begin
            errors++;
            $display("FAIL q_ovf: got %b, expected %b", q_ovf, m_ovf);
        end
        checks++;
        if (drop_cnt !== 8'(m_drop)) begin
            errors++;
            $display("FAIL drop_cnt: got %0d, expected %0d", drop_cnt, m_drop);
        end
        rtc_ns = rtc_ns + 8;
        if (rtc_ns >= NS_PER_SEC) begin
            rtc_ns  = rtc_ns - NS_PER_SEC;
            rtc_sec = rtc_sec + 48'd1;
        end
        drive_rtc();
    endtask

    task automatic pulse(input logic [TAG_W-1:0] tag);
        ts_trig = 1'b1;
        ts_tag  = tag;
        step();
        ts_trig = 1'b0;
        step();
    endtask

    task automatic drain();
        int unsigned n;
        n    = sb.size();
        q_rd = 1'b1;
        for (int unsigned i = 0; i < n; i++) step();
        q_rd = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; ts_trig = 1'b0; ts_tag = '0; q_rd = 1'b0; ovf_clr = 1'b0;
        load_rtc(48'd0, 0);
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (q_valid !== 1'b0 || q_cnt !== '0 || q_ovf !== 1'b0 || drop_cnt !== 8'd0 ||
            q_sec !== '0 || q_ns !== '0 || q_tag !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b cnt=%0d ovf=%b drop=%0d sec=%0d ns=%h tag=%h, expected all zero",
                     q_valid, q_cnt, q_ovf, drop_cnt, q_sec, q_ns, q_tag);
        end
    endtask

    task automatic test_single_capture();
        load_rtc(48'd10, 999999990);
        step();
        ts_trig = 1'b1;
        ts_tag  = 16'hA5A5;
        step();
        ts_trig = 1'b0;
        checks++;
        if (q_valid !== 1'b1 || q_sec !== 48'd10 || q_ns[37:8] !== 30'd999999998 || q_cnt !== 3'd1) begin
            errors++;
            $display("FAIL single_capture: got valid=%b sec=%0d ns=%0d cnt=%0d, expected valid=1 sec=10 ns=999999998 cnt=1",
                     q_valid, q_sec, q_ns[37:8], q_cnt);
        end
        drain();
        checks++;
        if (q_sec !== '0 || q_ns !== '0 || q_tag !== '0) begin
            errors++;
            $display("FAIL empty_fields: got sec=%0d ns=%h tag=%h, expected 0", q_sec, q_ns, q_tag);
        end
    endtask

    task automatic test_rollover();
        load_rtc(48'd10, 999999990);
        step();
        step();
        ts_trig = 1'b1;
        ts_tag  = 16'h0011;
        step();
        ts_trig = 1'b0;
        checks++;
        if (q_sec !== 48'd11 || q_ns[37:8] !== 30'd6) begin
            errors++;
            $display("FAIL rollover: got sec=%0d ns=%0d, expected sec=11 ns=6", q_sec, q_ns[37:8]);
        end
        drain();
    endtask

    task automatic test_fill_overflow();
        for (int unsigned i = 1; i <= 6; i++) pulse(TAG_W'(i));
        checks++;
        if (q_cnt !== 3'd4 || q_ovf !== 1'b1 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL fill_overflow: got cnt=%0d ovf=%b drop=%0d, expected cnt=4 ovf=1 drop=2",
                     q_cnt, q_ovf, drop_cnt);
        end
        q_rd = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) begin
            checks++;
            if (q_tag !== TAG_W'(i)) begin
                errors++;
                $display("FAIL overflow_order: got tag=%0d, expected %0d", q_tag, i);
            end
            step();
        end
        q_rd = 1'b0;
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drained: got valid=%b, expected 0", q_valid);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (q_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b, expected 0", q_ovf);
        end
    endtask

    task automatic test_back_to_back();
        for (int unsigned i = 11; i <= 14; i++) pulse(TAG_W'(i));
        ts_trig = 1'b1;
        ts_tag  = 16'd15;
        q_rd    = 1'b1;
        step();
        ts_trig = 1'b0;
        q_rd    = 1'b0;
        checks++;
        if (q_cnt !== 3'd4 || q_ovf !== 1'b0 || q_tag !== 16'd12) begin
            errors++;
            $display("FAIL full_push_pop: got cnt=%0d ovf=%b head=%0d, expected cnt=4 ovf=0 head=12",
                     q_cnt, q_ovf, q_tag);
        end
        step();
        drain();
    endtask

    task automatic test_ovf_clr_vs_drop();
        for (int unsigned i = 21; i <= 24; i++) pulse(TAG_W'(i));
        ts_trig = 1'b1;
        ts_tag  = 16'd25;
        ovf_clr = 1'b1;
        step();
        ts_trig = 1'b0;
        ovf_clr = 1'b0;
        checks++;
        if (q_ovf !== 1'b1 || drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL ovf_set_wins: got ovf=%b drop=%0d, expected ovf=1 drop=3", q_ovf, drop_cnt);
        end
        step();
        drain();
    endtask

    task automatic test_held_trigger();
        ts_trig = 1'b1;
        ts_tag  = 16'h0777;
        for (int i = 0; i < 10; i++) step();
        ts_trig = 1'b0;
        step();
        checks++;
        if (q_cnt !== 3'd1 || q_tag !== 16'h0777) begin
            errors++;
            $display("FAIL held_trigger: got cnt=%0d tag=%h, expected cnt=1 tag=0777", q_cnt, q_tag);
        end
        drain();
    endtask

    task automatic test_saturation();
        for (int unsigned i = 0; i < 304; i++) pulse(TAG_W'(100 + i));
        checks++;
        if (drop_cnt !== 8'd255 || q_cnt !== 3'd4) begin
            errors++;
            $display("FAIL drop_saturation: got drop=%0d cnt=%0d, expected drop=255 cnt=4", drop_cnt, q_cnt);
        end
        drain();
    endtask

    task automatic test_reset_midop();
        pulse(16'd31);
        pulse(16'd32);
        ts_trig = 1'b1;
        ts_tag  = 16'd33;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (q_cnt !== '0 || q_valid !== 1'b0 || q_ovf !== 1'b0 || drop_cnt !== 8'd0 ||
            q_sec !== '0 || q_ns !== '0 || q_tag !== '0) begin
            errors++;
            $display("FAIL reset_midop: got cnt=%0d valid=%b ovf=%b drop=%0d sec=%0d ns=%h tag=%h, expected all zero",
                     q_cnt, q_valid, q_ovf, drop_cnt, q_sec, q_ns, q_tag);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (q_cnt !== '0) begin
            errors++;
            $display("FAIL no_capture_after_reset: got cnt=%0d, expected 0", q_cnt);
        end
        ts_trig = 1'b0;
        step();
        ts_trig = 1'b1;
        ts_tag  = 16'd34;
        step();
        ts_trig = 1'b0;
        checks++;
        if (q_cnt !== 3'd1 || q_tag !== 16'd34) begin
            errors++;
            $display("FAIL capture_after_reset: got cnt=%0d tag=%0d, expected cnt=1 tag=34", q_cnt, q_tag);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_rollover();
        test_fill_overflow();
        test_back_to_back();
        test_ovf_clr_vs_drop();
        test_held_trigger();
        test_saturation();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
